if_stage: RTL and testbench

Instruction-fetch stage with PC register, instruction-memory request/response handshake, and the IF/ID pipeline register.
- Feeds the decode stage.
- Consumes PCEnable and IF_ID_writeEnable from the load-use hazard unit.
- Consumes flush_i/branch_target from the branch-resolution stage.
- One memory request outstanding at most. A one-entry hold buffer absorbs responses that arrive while IF/ID is stalled.

---
 rtl/if_pkg.sv | 19 +
 rtl/if_id_reg.sv | 33 +++
 rtl/if_stage.sv | 122 ++++++++++++
 tb/tb_if_stage.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared fetch-stage types: fetch FSM encoding and the IF/ID payload handed to decode.
// Pure declarations; no latency or backpressure of its own.
package if_pkg;

  localparam int          XLEN = 64;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register between fetch and decode with write-enable and flush-to-bubble.
// 1-cycle latency; write_en=0 holds contents, flush overrides write_en.
module if_id_reg
  import if_pkg::*;
#(
  parameter logic [31:0] BUBBLE = NOP
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   write_en,
  input  logic   flush,
  input  logic   load,
  input  if_id_t d,
  output if_id_t q
);

  // A bubble keeps the old pc so decode-side debug still sees the last fetch address.
  always_ff @(posedge clk) begin
    if (reset) begin
      q.pc    <= '0;
      q.instr <= BUBBLE;
      q.valid <= 1'b0;
    end else if (flush || (write_en && !load)) begin
      q.instr <= BUBBLE;
      q.valid <= 1'b0;
    end else if (write_en) begin
      q.pc    <= d.pc;
      q.instr <= d.instr;
      q.valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, single-outstanding imem handshake, one-entry hold buffer, IF/ID register.
// Response reaches IF/ID one edge after rvalid; IF/ID stall parks it in the hold buffer and blocks new requests.
module if_stage #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP      = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PCEnable,
  input  logic            IF_ID_writeEnable,
  input  logic            flush_i,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] IF_ID_pc,
  output logic [31:0]     IF_ID_instr,
  output logic            IF_ID_valid
);

  import if_pkg::*;

  fetch_state_t    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] fetch_pc_q;
  logic            kill_q;
  if_id_t          hold_q;

  logic   in_wait;
  logic   rsp_live;
  logic   rsp_accept;
  logic   grant;
  logic   load_ifid;
  if_id_t ifid_d;
  if_id_t ifid_q;

  assign in_wait    = (state_q == WAIT);
  assign rsp_live   = in_wait & imem_rvalid & ~kill_q;
  assign rsp_accept = imem_rvalid & ~kill_q & IF_ID_writeEnable;

  // Re-requesting in the response cycle is what sustains 1 instr/cycle on a 1-cycle memory.
  assign imem_req  = ~reset & ~flush_i & PCEnable & ~hold_q.valid
                   & (~in_wait | rsp_accept);
  assign imem_addr = pc_q;
  assign grant     = imem_req & imem_gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      fetch_pc_q   <= '0;
      kill_q       <= 1'b0;
      hold_q.pc    <= '0;
      hold_q.instr <= NOP;
      hold_q.valid <= 1'b0;
    end else if (flush_i) begin
      pc_q         <= branch_target;
      hold_q.valid <= 1'b0;
      // An in-flight fetch still has to come back; mark it so it is dropped on arrival.
      if (in_wait) begin
        if (imem_rvalid) begin
          state_q <= IDLE;
          kill_q  <= 1'b0;
        end else begin
          kill_q  <= 1'b1;
        end
      end
    end else begin
      if (grant) begin
        fetch_pc_q <= pc_q;
        pc_q       <= pc_q + XLEN'(4);
        state_q    <= WAIT;
      end else if (in_wait && imem_rvalid) begin
        state_q    <= IDLE;
      end

      if (in_wait && imem_rvalid && kill_q) begin
        kill_q <= 1'b0;
      end

      if (rsp_live && !IF_ID_writeEnable) begin
        hold_q.pc    <= fetch_pc_q;
        hold_q.instr <= imem_rdata;
        hold_q.valid <= 1'b1;
      end else if (hold_q.valid && IF_ID_writeEnable) begin
        hold_q.valid <= 1'b0;
      end
    end
  end

  // Hold buffer and a live response are never both present: parking needs a stall, which blocks requests.
  always_comb begin
    ifid_d = hold_q;
    if (!hold_q.valid) begin
      ifid_d.pc    = fetch_pc_q;
      ifid_d.instr = imem_rdata;
    end
    ifid_d.valid = 1'b1;
  end

  assign load_ifid = rsp_live | hold_q.valid;

  if_id_reg #(
    .BUBBLE (NOP)
  ) u_if_id_reg (
    .clk      (clk),
    .reset    (reset),
    .write_en (IF_ID_writeEnable),
    .flush    (flush_i),
    .load     (load_ifid),
    .d        (ifid_d),
    .q        (ifid_q)
  );

  assign IF_ID_pc    = ifid_q.pc;
  assign IF_ID_instr = ifid_q.instr;
  assign IF_ID_valid = ifid_q.valid;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed cycle table followed by a randomized run against a program-order model.
module tb_if_stage;

  localparam logic [31:0] NOPW = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        PCEnable;
  logic        IF_ID_writeEnable;
  logic        flush_i;
  logic [63:0] branch_target;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [63:0] IF_ID_pc;
  logic [31:0] IF_ID_instr;
  logic        IF_ID_valid;

  if_stage dut (
    .clk               (clk),
    .reset             (reset),
    .PCEnable          (PCEnable),
    .IF_ID_writeEnable (IF_ID_writeEnable),
    .flush_i           (flush_i),
    .branch_target     (branch_target),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_gnt          (imem_gnt),
    .imem_rvalid       (imem_rvalid),
    .imem_rdata        (imem_rdata),
    .IF_ID_pc          (IF_ID_pc),
    .IF_ID_instr       (IF_ID_instr),
    .IF_ID_valid       (IF_ID_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) + 32'h0000_0101;
  endfunction

  typedef struct {
    logic        rst, pcen, we, fl;
    logic [63:0] tgt;
    logic        gnt, rv;
    logic [31:0] rdata;
    logic        req;
    logic [63:0] addr;
    logic        v;
    logic [63:0] pc;
    logic [31:0] instr;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic pcen, input logic we, input logic fl,
                              input logic [63:0] tgt, input logic gnt, input logic rv,
                              input logic [31:0] rdata, input logic req, input logic [63:0] addr,
                              input logic v, input logic [63:0] pc, input logic [31:0] instr);
    vec_t r;
    r.rst = rst; r.pcen = pcen; r.we = we; r.fl = fl; r.tgt = tgt; r.gnt = gnt; r.rv = rv;
    r.rdata = rdata; r.req = req; r.addr = addr; r.v = v; r.pc = pc; r.instr = instr;
    return r;
  endfunction

  localparam int NV = 27;
  vec_t tbl[NV];

  // Random-phase model state
  logic        pend;
  int          cnt;
  logic        resp_now;
  logic [63:0] paddr;
  logic [63:0] exp_fetch;
  logic [63:0] exp_if_pc;
  logic        prev_rst, prev_fl, prev_we, prev_v;
  logic [63:0] prev_tgt, prev_pc;
  logic [31:0] prev_instr;
  logic        r_pcen, r_we, r_fl, r_gnt, legal;
  logic [63:0] r_tgt;
  int          delivered;

  initial begin
    // rst pcen we fl tgt  gnt rv rdata   | req addr   v pc   instr
    tbl[0]  = mk(1,1,1,0,0,     1,0,0,                0,64'h0,  0,64'h0,NOPW);
    tbl[1]  = mk(0,1,1,0,0,     1,0,0,                1,64'h0,  0,64'h0,NOPW);
    tbl[2]  = mk(0,1,1,0,0,     1,1,mem_word(64'h0),  1,64'h4,  0,64'h0,NOPW);
    tbl[3]  = mk(0,1,1,0,0,     1,1,mem_word(64'h4),  1,64'h8,  1,64'h0,mem_word(64'h0));
    tbl[4]  = mk(0,0,0,0,0,     1,1,mem_word(64'h8),  0,64'hC,  1,64'h4,mem_word(64'h4));
    tbl[5]  = mk(0,0,0,0,0,     1,0,0,                0,64'hC,  1,64'h4,mem_word(64'h4));
    tbl[6]  = mk(0,1,1,0,0,     1,0,0,                0,64'hC,  1,64'h4,mem_word(64'h4));
    tbl[7]  = mk(0,1,1,0,0,     1,0,0,                1,64'hC,  1,64'h8,mem_word(64'h8));
    tbl[8]  = mk(0,0,1,0,0,     1,1,mem_word(64'hC),  0,64'h10, 0,64'h8,NOPW);
    tbl[9]  = mk(0,0,1,0,0,     1,0,0,                0,64'h10, 1,64'hC,mem_word(64'hC));
    tbl[10] = mk(1,1,1,0,0,     1,0,0,                0,64'h10, 0,64'hC,NOPW);
    tbl[11] = mk(0,1,1,0,0,     1,0,0,                1,64'h0,  0,64'h0,NOPW);
    tbl[12] = mk(0,1,1,0,0,     1,0,0,                0,64'h4,  0,64'h0,NOPW);
    tbl[13] = mk(0,1,1,1,64'h100,1,0,0,               0,64'h4,  0,64'h0,NOPW);
    tbl[14] = mk(0,1,1,0,0,     1,1,mem_word(64'h0),  0,64'h100,0,64'h0,NOPW);
    tbl[15] = mk(0,1,1,0,0,     1,0,0,                1,64'h100,0,64'h0,NOPW);
    tbl[16] = mk(0,1,1,0,0,     1,0,0,                0,64'h104,0,64'h0,NOPW);
    tbl[17] = mk(0,1,1,0,0,     1,0,0,                0,64'h104,0,64'h0,NOPW);
    tbl[18] = mk(0,1,0,1,64'h100,1,1,mem_word(64'h100),0,64'h104,0,64'h0,NOPW);
    tbl[19] = mk(0,1,1,0,0,     1,0,0,                1,64'h100,0,64'h0,NOPW);
    tbl[20] = mk(1,1,1,0,0,     1,0,0,                0,64'h104,0,64'h0,NOPW);
    tbl[21] = mk(0,1,1,0,0,     0,1,mem_word(64'h100),1,64'h0,  0,64'h0,NOPW);
    tbl[22] = mk(0,1,1,0,0,     0,0,0,                1,64'h0,  0,64'h0,NOPW);
    tbl[23] = mk(0,1,1,0,0,     1,0,0,                1,64'h0,  0,64'h0,NOPW);
    tbl[24] = mk(0,0,1,0,0,     1,1,mem_word(64'h0),  0,64'h4,  0,64'h0,NOPW);
    tbl[25] = mk(0,0,1,0,0,     1,0,0,                0,64'h4,  1,64'h0,mem_word(64'h0));
    tbl[26] = mk(0,0,1,0,0,     1,0,0,                0,64'h4,  0,64'h0,NOPW);

    reset = 1'b1; PCEnable = 1'b0; IF_ID_writeEnable = 1'b0; flush_i = 1'b0;
    branch_target = '0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      reset = tbl[i].rst; PCEnable = tbl[i].pcen; IF_ID_writeEnable = tbl[i].we;
      flush_i = tbl[i].fl; branch_target = tbl[i].tgt; imem_gnt = tbl[i].gnt;
      imem_rvalid = tbl[i].rv; imem_rdata = tbl[i].rdata;
      #1;
      check($sformatf("row%0d_req", i),   {63'd0, imem_req},    {63'd0, tbl[i].req});
      check($sformatf("row%0d_addr", i),  imem_addr,            tbl[i].addr);
      check($sformatf("row%0d_valid", i), {63'd0, IF_ID_valid}, {63'd0, tbl[i].v});
      check($sformatf("row%0d_pc", i),    IF_ID_pc,             tbl[i].pc);
      check($sformatf("row%0d_instr", i), {32'd0, IF_ID_instr}, {32'd0, tbl[i].instr});
    end

    // Randomized run: memory with 1..3 cycle latency, random stalls, grants and flushes.
    @(negedge clk);
    reset = 1'b1; flush_i = 1'b0; imem_rvalid = 1'b0; imem_gnt = 1'b0;
    repeat (2) @(posedge clk);
    pend = 1'b0; cnt = 0; paddr = '0; exp_fetch = '0; exp_if_pc = '0;
    prev_rst = 1'b1; prev_fl = 1'b0; prev_we = 1'b0; prev_tgt = '0;
    prev_v = 1'b0; prev_pc = '0; prev_instr = NOPW; delivered = 0;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      resp_now = pend && (cnt == 0);
      if (pend && cnt != 0) cnt--;
      r_pcen = ($urandom % 4) != 0;
      r_we   = ($urandom % 4) != 0;
      r_fl   = ($urandom % 16) == 0;
      r_tgt  = 64'($urandom_range(0, 1023)) * 64'd4;
      r_gnt  = ($urandom % 3) != 0;
      reset = 1'b0; PCEnable = r_pcen; IF_ID_writeEnable = r_we; flush_i = r_fl;
      branch_target = r_tgt; imem_gnt = r_gnt; imem_rvalid = resp_now;
      imem_rdata = resp_now ? mem_word(paddr) : $urandom;
      #1;

      if (prev_rst) begin
        check("rnd_reset_valid", {63'd0, IF_ID_valid}, 64'd0);
        check("rnd_reset_instr", {32'd0, IF_ID_instr}, {32'd0, NOPW});
        check("rnd_reset_pc",    IF_ID_pc, 64'd0);
      end else if (prev_fl) begin
        check("rnd_flush_valid", {63'd0, IF_ID_valid}, 64'd0);
        check("rnd_flush_instr", {32'd0, IF_ID_instr}, {32'd0, NOPW});
        exp_if_pc = prev_tgt;
      end else if (!prev_we) begin
        check("rnd_stall_valid", {63'd0, IF_ID_valid}, {63'd0, prev_v});
        check("rnd_stall_pc",    IF_ID_pc, prev_pc);
        check("rnd_stall_instr", {32'd0, IF_ID_instr}, {32'd0, prev_instr});
      end else if (IF_ID_valid) begin
        check("rnd_deliver_pc",    IF_ID_pc, exp_if_pc);
        check("rnd_deliver_instr", {32'd0, IF_ID_instr}, {32'd0, mem_word(exp_if_pc)});
        exp_if_pc = exp_if_pc + 64'd4;
        delivered++;
      end else begin
        check("rnd_bubble_instr", {32'd0, IF_ID_instr}, {32'd0, NOPW});
        check("rnd_bubble_pc",    IF_ID_pc, prev_pc);
      end

      if (imem_req) begin
        legal = r_pcen && !r_fl && (!pend || resp_now);
        check("rnd_req_legal", {63'd0, legal}, 64'd1);
        check("rnd_req_addr",  imem_addr, exp_fetch);
      end

      if (r_fl) exp_fetch = r_tgt;
      else if (imem_req && r_gnt) exp_fetch = exp_fetch + 64'd4;
      if (resp_now) pend = 1'b0;
      if (imem_req && r_gnt) begin
        pend  = 1'b1;
        cnt   = $urandom_range(0, 2);
        paddr = imem_addr;
      end

      prev_rst = 1'b0; prev_fl = r_fl; prev_we = r_we; prev_tgt = r_tgt;
      prev_v = IF_ID_valid; prev_pc = IF_ID_pc; prev_instr = IF_ID_instr;
    end

    check("rnd_throughput", {63'd0, delivered >= 100}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
